// File: rtl/result_select_pkg.sv
// Shared types and constants for the registered arithmetic result selector.
package result_select_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_e;

  localparam int unsigned CH_DIV  = 0;
  localparam int unsigned CH_MULT = 1;
  localparam int unsigned CH_SQRT = 2;

  localparam int unsigned DEF_NBITS   = 16;
  localparam int unsigned DEF_NCHAN   = 3;
  localparam int unsigned DEF_TIMEOUT = 64;

  // Selector width, never narrower than one bit.
  function automatic int unsigned sel_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/result_select_reg_if.sv
// Request/done/result bundle between the arithmetic units, consumer and result_select_reg.
interface result_select_reg_if
  import result_select_pkg::*;
#(
  parameter int unsigned NBits = DEF_NBITS,
  parameter int unsigned NChan = DEF_NCHAN
) ();

  localparam int unsigned SelBits = sel_bits(NChan);

  logic                   Start;
  logic [SelBits-1:0]     Selector;
  logic [NChan-1:0]       Done_i;
  logic [NChan*NBits-1:0] Data_i;
  logic                   Ack_i;
  logic [NBits-1:0]       Result_o;
  logic                   Valid_o;
  logic                   Busy_o;
  logic                   Error_o;

  modport master (
    output Start, Selector, Done_i, Data_i, Ack_i,
    input  Result_o, Valid_o, Busy_o, Error_o
  );

  modport slave (
    input  Start, Selector, Done_i, Data_i, Ack_i,
    output Result_o, Valid_o, Busy_o, Error_o
  );

endinterface

// File: rtl/result_select_reg_wd_counter.sv
// Up-counter with synchronous clear; tc flags the final count before Limit is reached.
module wd_counter #(
  parameter int unsigned Limit = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned Width = (Limit > 1) ? $clog2(Limit) : 1;

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // High during the Limit-th enabled cycle after a clear.
  assign tc = (count_q == Width'(Limit - 1));

endmodule

// File: rtl/result_select_reg.sv
// Waits for the selected arithmetic unit's done pulse and holds its result under valid/ack.
// Define RESULT_SELECT_TIMEOUT_EN to add a WAIT-state watchdog of TimeoutCycles cycles.
module result_select_reg
  import result_select_pkg::*;
#(
  parameter int unsigned NBits         = DEF_NBITS,
  parameter int unsigned NChan         = DEF_NCHAN,
  parameter int unsigned TimeoutCycles = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset,
  result_select_reg_if.slave   bus
);

  localparam int unsigned SelBits = sel_bits(NChan);

  state_e             state_q, state_d;
  logic [SelBits-1:0] sel_q, sel_d;
  logic [NBits-1:0]   result_q, result_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               error_q, error_d;

  logic start_ok, start_bad, capture, timeout;

  assign start_ok  = bus.Start && (32'(bus.Selector) < NChan);
  assign start_bad = bus.Start && (32'(bus.Selector) >= NChan);
  assign capture   = (state_q == WAIT) && bus.Done_i[sel_q];

`ifdef RESULT_SELECT_TIMEOUT_EN
  wd_counter #(
    .Limit (TimeoutCycles)
  ) u_wd_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q != WAIT),
    .en    (state_q == WAIT),
    .tc    (timeout)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TimeoutCycles;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = WAIT;
          sel_d   = bus.Selector;
        end
      end
      // A done on the timeout cycle still wins.
      WAIT: begin
        if (capture) begin
          state_d = HOLD;
        end else if (timeout) begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (bus.Ack_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    result_d = result_q;
    if (capture) begin
      result_d = bus.Data_i[32'(sel_q) * NBits +: NBits];
    end
    valid_d = (state_d == HOLD);
    busy_d  = (state_d != IDLE);
    error_d = ((state_q == IDLE) && start_bad) ||
              ((state_q == WAIT) && !capture && timeout);
  end

  assign bus.Result_o = result_q;
  assign bus.Valid_o  = valid_q;
  assign bus.Busy_o   = busy_q;
  assign bus.Error_o  = error_q;

endmodule

// File: doc/result_select_reg.md
Name: result_select_reg

Overview:
- Parametrised, registered successor to the combinational 3-way result selector that feeds the multiplier/divider/square-root datapath output.
- A `start` pulse latches which arithmetic unit (channel) to wait on. The block waits for that unit's done pulse, captures its result, and holds it under a valid/ack handshake.
- Generalised to NChan channels of NBits data each; adds illegal-selector error reporting.

Parameters:
- NBits, 16, width of each channel's result and of Result_o.
- NChan, 3, number of arithmetic channels (0=division, 1=multiplication, 2=square root; more allowed).
- TimeoutCycles, 64, WAIT-state watchdog limit in cycles; used only with RESULT_SELECT_TIMEOUT_EN.
- SelBits (localparam), $clog2(NChan) with a minimum of 1; selector width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous reset, active-high.
- Start  input  1  single-cycle request; Selector sampled on the same cycle.
- Selector  input  SelBits  channel index to wait on.
- Done_i  input  NChan  per-channel done pulses from the arithmetic units.
- Data_i  input  NChan*NBits  flattened channel results; channel k occupies bits [k*NBits +: NBits].
- Ack_i  input  1  consumer acknowledge of Result_o.
- Result_o  output  NBits  captured result.
- Valid_o  output  1  Result_o is valid and held.
- Busy_o  output  1  an operation is in progress (WAIT or HOLD).
- Error_o  output  1  one-cycle error pulse.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, sel_q=0, Result_o=0, Valid_o=0, Busy_o=0, Error_o=0. Any operation in flight is discarded.
- All outputs are registered.
- IDLE, on Start=1:
  - Selector<NChan: latch sel_q=Selector, go to WAIT; Busy_o=1 from the next cycle.
  - Selector>=NChan: Error_o=1 for exactly one cycle, stay in IDLE, Result_o unchanged.
- WAIT:
  - Done_i[sel_q]=1 in cycle t: Result_o=Data_i[sel_q] and Valid_o=1 at t+1; go to HOLD. Latency from done to valid is 1 cycle.
  - Done_i on other channels is ignored.
  - Start is ignored; Selector changes have no effect.
- HOLD:
  - Result_o and Valid_o stay stable until Ack_i=1.
  - On Ack_i=1: Valid_o=0 and Busy_o=0 next cycle; go to IDLE.
  - Start in HOLD is ignored, including on the Ack cycle; a new Start is accepted only from the cycle after the return to IDLE.
  - Done_i is ignored.
- Ack_i outside HOLD is ignored.
- Result_o keeps its last captured value after Ack; it is not cleared.
- A Done pulse coincident with Start in IDLE is not captured; capture happens only in WAIT.
- Without the optional feature, WAIT has no exit except Done_i[sel_q] or reset.
- Error_o is never sticky; it is a one-cycle pulse.

Optional Feature:
- Macro: RESULT_SELECT_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TimeoutCycles without Done_i[sel_q]: go to IDLE, Error_o pulses 1 cycle, Busy_o=0, Valid_o stays 0, Result_o unchanged.
  - If Done arrives on the same cycle as the timeout, Done wins: the result is captured and no error is raised.
- Undefined: no counter logic; TimeoutCycles is unused; WAIT waits indefinitely.

Decomposition:
- Package result_select_pkg:
  - state typedef enum {IDLE, WAIT, HOLD};
  - channel index constants CH_DIV=0, CH_MULT=1, CH_SQRT=2;
  - default width constants.
- Sub-module wd_counter: parametrised up-counter with clear and terminal-count flag. Instantiated only under RESULT_SELECT_TIMEOUT_EN.
- Channel slice extraction and FSM stay in the top module.

Test Plan:
- Reset: assert reset mid-WAIT -> all outputs 0, state IDLE; a following Done_i[1] produces no Valid_o.
- Multiplication path: Start with Selector=1; two cycles later Done_i=3'b010, Data_i ch1=16'h00A5 -> next cycle Result_o=16'h00A5, Valid_o=1; held 5 cycles; Ack_i -> Valid_o=0, Busy_o=0.
- Wrong-channel done: Selector=2; Done_i=3'b001 with ch0=16'h1111 -> no capture; then Done_i=3'b100 with ch2=16'h0010 -> Result_o=16'h0010.
- Illegal selector: Selector=3 with NChan=3 plus Start -> Error_o=1 for one cycle, Busy_o stays 0.
- Start during HOLD and on the Ack cycle -> ignored; Start one cycle after return to IDLE -> accepted, Busy_o=1.
- With RESULT_SELECT_TIMEOUT_EN and TimeoutCycles=8: Start, no Done -> after 8 WAIT cycles Error_o pulses and Busy_o=0. Repeat with Done on cycle 8 -> Valid_o=1, no error.
